// File: rtl/hilo_pkg.sv
// Shared ALUControl codes for the HI/LO instruction group and the multiplier FSM state type.
package hilo_pkg;

  localparam logic [4:0] ALU_MFHI = 5'b01101;
  localparam logic [4:0] ALU_MFLO = 5'b01110;
  localparam logic [4:0] ALU_MTHI = 5'b01111;
  localparam logic [4:0] ALU_MTLO = 5'b10000;
  localparam logic [4:0] ALU_MULT = 5'b10001;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic is_hilo_code(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_MFHI) || (code == ALU_MFLO) ||
           (code == ALU_MTHI) || (code == ALU_MTLO);
  endfunction

endpackage

// File: rtl/hilo_mult_unit_mult_iter_core.sv
// Iterative shift-add multiplier on operand magnitudes with a final sign fix-up.
// Define HILO_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module mult_iter_core
  import hilo_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              unsigned_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] product,
  output state_t            state
);

`ifdef HILO_RADIX4_EN
  localparam int LAST = XLEN / 2 - 1;
`else
  localparam int LAST = XLEN - 1;
`endif

  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic              neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc_next;

  // Two's-complement magnitude; 0x80000000 maps to itself and is then read as unsigned.
  assign a_mag = (!unsigned_op && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign b_mag = (!unsigned_op && b[XLEN-1]) ? (~b + 1'b1) : b;

  // acc holds {partial upper half, remaining multiplier bits}; the sum carry shifts back in.
`ifdef HILO_RADIX4_EN
  logic [XLEN+1:0] mcand3;
  logic [XLEN+1:0] addend;
  logic [XLEN+1:0] sum;

  always_comb begin
    addend = '0;
    case (acc[1:0])
      2'd1:    addend = {2'b00, mcand};
      2'd2:    addend = {1'b0, mcand, 1'b0};
      2'd3:    addend = mcand3;
      default: addend = '0;
    endcase
    sum      = {2'b00, acc[2*XLEN-1:XLEN]} + addend;
    acc_next = {sum, acc[XLEN-1:2]};
  end
`else
  logic [XLEN:0] sum;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[XLEN-1:1]};
  end
`endif

  assign done    = (state == BUSY) && (cnt == CNT_W'(LAST));
  assign product = neg ? (~acc_next + 1'b1) : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      neg    <= 1'b0;
`ifdef HILO_RADIX4_EN
      mcand3 <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            acc    <= {{XLEN{1'b0}}, b_mag};
            neg    <= (a[XLEN-1] ^ b[XLEN-1]) & ~unsigned_op;
            cnt    <= '0;
            state  <= BUSY;
`ifdef HILO_RADIX4_EN
            mcand3 <= {2'b00, a_mag} + {1'b0, a_mag, 1'b0};
`endif
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO register file with background multiplier and PC stall interlock.
// Optional build macro: HILO_RADIX4_EN (radix-4 multiplier, 16 busy cycles).
module hilo_mult_unit
  import hilo_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [4:0]      ALUControl,
  input  logic            unsigned_op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] mf_result,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall
);

  logic              is_hilo;
  logic              do_mult;
  logic              do_mfhi;
  logic              do_mflo;
  logic              do_mthi;
  logic              do_mtlo;
  logic              mult_done;
  logic [2*XLEN-1:0] mult_product;
  state_t            mult_state;

  assign is_hilo = op_valid && is_hilo_code(ALUControl);
  assign busy    = (mult_state == BUSY);
  assign stall   = busy & is_hilo;

  // A stalled op is re-presented each cycle, so accepting it only when stall=0 suffices.
  assign do_mult = op_valid && !stall && (ALUControl == ALU_MULT);
  assign do_mfhi = op_valid && !stall && (ALUControl == ALU_MFHI);
  assign do_mflo = op_valid && !stall && (ALUControl == ALU_MFLO);
  assign do_mthi = op_valid && !stall && (ALUControl == ALU_MTHI);
  assign do_mtlo = op_valid && !stall && (ALUControl == ALU_MTLO);

  always_comb begin
    mf_result = '0;
    if (do_mfhi)      mf_result = hi;
    else if (do_mflo) mf_result = lo;
  end

  mult_iter_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (do_mult),
    .unsigned_op (unsigned_op),
    .a           (rs_data),
    .b           (rt_data),
    .done        (mult_done),
    .product     (mult_product),
    .state       (mult_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (mult_done) begin
      hi <= mult_product[2*XLEN-1:XLEN];
      lo <= mult_product[XLEN-1:0];
    end else begin
      if (do_mthi) hi <= rs_data;
      if (do_mtlo) lo <= rs_data;
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit; busy length follows HILO_RADIX4_EN.
module tb_hilo_mult_unit;

`ifdef HILO_RADIX4_EN
  localparam int BUSY_CYC = 16;
`else
  localparam int BUSY_CYC = 32;
`endif

  localparam logic [4:0] C_MFHI = 5'b01101;
  localparam logic [4:0] C_MFLO = 5'b01110;
  localparam logic [4:0] C_MTHI = 5'b01111;
  localparam logic [4:0] C_MTLO = 5'b10000;
  localparam logic [4:0] C_MULT = 5'b10001;
  localparam logic [4:0] C_ADD  = 5'b00110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [4:0]  alu_ctl = '0;
  logic        unsigned_op = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] mf_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  hilo_mult_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .ALUControl  (alu_ctl),
    .unsigned_op (unsigned_op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .mf_result   (mf_result),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .stall       (stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0;
    alu_ctl  = '0;
  endtask

  task automatic issue_mult(input logic [31:0] a, input logic [31:0] b, input logic uns);
    @(posedge clk); #1;
    op_valid = 1'b1; alu_ctl = C_MULT; unsigned_op = uns; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Issue, count busy cycles, then compare hi/lo against the queued expectation.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic uns,
                         input string tag);
    int n;
    logic [63:0] exp;
    issue_mult(a, b, uns);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    check({tag, "_busy_cycles"}, 64'(n), 64'(BUSY_CYC));
    check({tag, "_hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
    check({tag, "_lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
  endtask

  task automatic present_mf(input logic [4:0] code, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    op_valid = 1'b1; alu_ctl = code;
    @(negedge clk);
    check({tag, "_stall"}, {63'b0, stall}, 64'd0);
    check({tag, "_mf_result"}, {32'b0, mf_result}, {32'b0, exp});
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin : main
    int n;
    // Reset state
    #2;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_stall", {63'b0, stall}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_mf", {32'b0, mf_result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Signed 7 * -3 = -21
    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    do_mult(32'd7, 32'hFFFFFFFD, 1'b0, "smul_7_m3");
    present_mf(C_MFLO, 32'hFFFFFFEB, "mflo_m21");
    present_mf(C_MFHI, 32'hFFFFFFFF, "mfhi_m21");

    // multu 0xFFFFFFFF^2, then the same operands signed (-1 * -1)
    exp_q.push_back(64'hFFFFFFFE_00000001);
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "umul_max");
    exp_q.push_back(64'h00000000_00000001);
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "smul_m1_m1");

    // Most-negative operand cases
    exp_q.push_back(64'h40000000_00000000);
    do_mult(32'h80000000, 32'h80000000, 1'b0, "smul_min_min");
    exp_q.push_back(64'hFFFFFFFF_80000000);
    do_mult(32'h80000000, 32'd1, 1'b0, "smul_min_1");

    // Interlock: add mid-multiply never stalls, mult while busy stalls without restart,
    // mfhi presented at cycle 5 stalls until busy falls.
    issue_mult(32'h00010000, 32'h00010000, 1'b0);
    @(posedge clk); #1;
    op_valid = 1'b1; alu_ctl = C_ADD;
    @(negedge clk);
    check("add_busy", {63'b0, busy}, 64'd1);
    check("add_stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    alu_ctl = C_MULT; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    check("mult_busy_stall", {63'b0, stall}, 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk); #1;
    op_valid = 1'b1; alu_ctl = C_MFHI;
    n = 0;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("mfhi_stall_cycles", 64'(n), 64'(BUSY_CYC - 5));
    check("mfhi_after_busy", {63'b0, busy}, 64'd0);
    check("mfhi_new_hi", {32'b0, mf_result}, 64'd1);
    check("mult_not_restarted_lo", {32'b0, lo}, 64'd0);
    @(posedge clk); #1;
    idle_inputs();

    // mthi / mtlo while idle, read back, then overwritten by a mult
    @(posedge clk); #1;
    op_valid = 1'b1; alu_ctl = C_MTHI; rs_data = 32'h12345678;
    @(posedge clk); #1;
    alu_ctl = C_MTLO; rs_data = 32'h9ABCDEF0;
    @(negedge clk);
    check("mthi_hi", {32'b0, hi}, 64'h12345678);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("mtlo_lo", {32'b0, lo}, 64'h9ABCDEF0);
    check("mtlo_hi_kept", {32'b0, hi}, 64'h12345678);
    present_mf(C_MFHI, 32'h12345678, "mfhi_mthi");
    present_mf(C_MFLO, 32'h9ABCDEF0, "mflo_mtlo");
    exp_q.push_back(64'h00000000_0000000C);
    do_mult(32'd3, 32'd4, 1'b1, "umul_3_4");

    // Asynchronous reset in the middle of a multiply, mfhi held pending
    issue_mult(32'd5, 32'd6, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    op_valid = 1'b1; alu_ctl = C_MFHI;
    #1;
    check("pre_rst_stall", {63'b0, stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_stall", {63'b0, stall}, 64'd0);
    check("arst_hi", {32'b0, hi}, 64'd0);
    check("arst_lo", {32'b0, lo}, 64'd0);
    check("arst_mf", {32'b0, mf_result}, 64'd0);
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(64'h00000000_0000001E);
    do_mult(32'd5, 32'd6, 1'b0, "smul_after_rst");

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
